arilla_lsu: RTL and testbench

Load/store unit that sits directly upstream of the on-chip memory on the arilla bus and acts as the core's data-side bus master. It accepts one byte-addressed RV32 load/store request at a time, converts it into a single word-aligned bus cycle with byte enables, and returns a sign- or zero-extended load result or a write acknowledge. Misaligned and illegal-width requests raise a fault without touching the bus.

---
 rtl/arilla_bus_if.sv | 24 ++
 rtl/arilla_lsu.sv | 138 +++++++++++++
 tb/tb_arilla_lsu.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/arilla_bus_if.sv
// Word-addressed arilla bus between a data-side master and on-chip memory.
// The master drives address/data/strobes; the slave returns data_in and intercept.
interface arilla_bus_if #(
    parameter int DataWidth    = 32,
    parameter int AddressWidth = 30
);
    logic [AddressWidth-1:0] address;
    logic [DataWidth-1:0]    data;
    logic [3:0]              byte_enable;
    logic                    read;
    logic                    write;
    logic [DataWidth-1:0]    data_in;
    logic                    intercept;

    modport master (
        output address, data, byte_enable, read, write,
        input  data_in, intercept
    );

    modport slave (
        input  address, data, byte_enable, read, write,
        output data_in, intercept
    );
endinterface

// File: rtl/arilla_lsu.sv
// RV32 load/store unit: one request at a time, turned into a single word-aligned
// arilla bus cycle with byte enables; loads are lane-selected and extended.
module arilla_lsu #(
    parameter int DataWidth    = 32,
    parameter int AddressWidth = 30
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [2:0]           req_funct3,
    input  logic [31:0]          req_addr,
    input  logic [DataWidth-1:0] req_wdata,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [DataWidth-1:0] resp_rdata,
    output logic                 resp_fault,
    arilla_bus_if.master         bus_interface
);

    typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, RESP} state_t;

    state_t     state, state_nxt;
    logic       lat_write;
    logic [2:0] lat_funct3;
    logic [1:0] lat_off;
    logic       req_fault;

    function automatic logic is_fault(input logic wr, input logic [2:0] f3, input logic [1:0] off);
        logic bad;
        bad = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
        bad = bad || (wr && (f3 > 3'd2));
        bad = bad || ((f3[1:0] == 2'd1) && off[0]);
        bad = bad || ((f3 == 3'd2) && (off != 2'd0));
        return bad;
    endfunction

    function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'd0:    return 4'b0001 << off;
            2'd1:    return 4'b0011 << {off[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [DataWidth-1:0] store_data(input logic [2:0] f3, input logic [DataWidth-1:0] wd);
        case (f3[1:0])
            2'd0:    return {4{wd[7:0]}};
            2'd1:    return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

    function automatic logic [DataWidth-1:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                                          input logic [DataWidth-1:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = word[{off[1], 4'b0000} +: 16];
        case (f3)
            3'd0:    return {{24{b[7]}}, b};
            3'd4:    return {24'd0, b};
            3'd1:    return {{16{h[15]}}, h};
            3'd5:    return {16'd0, h};
            default: return word;
        endcase
    endfunction

    assign req_fault = is_fault(req_write, req_funct3, req_addr[1:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Strobes are decoded from state so an asynchronous reset drops them at once.
    always_comb begin
        state_nxt           = state;
        req_ready           = 1'b0;
        resp_valid          = 1'b0;
        bus_interface.read  = 1'b0;
        bus_interface.write = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = req_fault ? RESP : ACCESS;
            end
            ACCESS: begin
                bus_interface.read  = !lat_write;
                bus_interface.write = lat_write;
                state_nxt           = lat_write ? RESP : CAPTURE;
            end
            CAPTURE: state_nxt = RESP;
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_write                 <= 1'b0;
            lat_funct3                <= 3'd0;
            lat_off                   <= 2'd0;
            resp_rdata                <= '0;
            resp_fault                <= 1'b0;
            bus_interface.address     <= '0;
            bus_interface.data        <= '0;
            bus_interface.byte_enable <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    lat_write  <= req_write;
                    lat_funct3 <= req_funct3;
                    lat_off    <= req_addr[1:0];
                    if (req_fault) begin
                        resp_fault <= 1'b1;
                        resp_rdata <= '0;
                    end else begin
                        bus_interface.address     <= req_addr[31 -: AddressWidth];
                        bus_interface.byte_enable <= byte_en(req_funct3, req_addr[1:0]);
                        bus_interface.data        <= req_write ? store_data(req_funct3, req_wdata) : '0;
                    end
                end
                CAPTURE: resp_rdata <= load_extend(lat_funct3, lat_off, bus_interface.data_in);
                RESP: if (resp_ready) begin
                    resp_fault <= 1'b0;
                    resp_rdata <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_arilla_lsu.sv
// Bench for arilla_lsu: a word memory behind the bus, directed requests, and a
// scoreboard queue checked by an independent response monitor.
module tb_arilla_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_fault;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
    } exp_t;
    exp_t exp_q[$];

    logic [31:0] mem [256];

    arilla_bus_if #(.DataWidth(32), .AddressWidth(30)) bif ();

    arilla_lsu #(.DataWidth(32), .AddressWidth(30)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_fault(resp_fault),
        .bus_interface(bif)
    );

    always #5 clk = ~clk;

    assign bif.data_in   = mem[bif.address[7:0]];
    assign bif.intercept = 1'b0;

    // Memory model: sole writer of mem
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        mem[8'h40] = 32'hDEADBEEF;
        mem[8'h42] = 32'h11111111;
        forever begin
            @(posedge clk);
            if (bif.write)
                for (int b = 0; b < 4; b++)
                    if (bif.byte_enable[b]) mem[bif.address[7:0]][8*b +: 8] <= bif.data[8*b +: 8];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Response monitor
    always @(negedge clk) begin
        if (rst_n === 1'b1 && resp_valid === 1'b1 && resp_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_resp: got rdata 0x%08h with no expected entry", resp_rdata);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("resp_rdata", resp_rdata, e.rdata);
                chk("resp_fault", 32'(resp_fault), 32'(e.fault));
            end
        end
    end

    task automatic do_req(input string name, input logic w, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic exp_f,
                          input logic [3:0] exp_be, input logic [31:0] exp_bd, input int hold);
        int lat;
        int exp_lat;
        exp_t e;
        exp_lat = exp_f ? 1 : (w ? 2 : 3);
        @(negedge clk);
        chk({name, ".req_ready"}, 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_write  = w;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        resp_ready = (hold == 0);
        e.rdata = exp_rd;
        e.fault = exp_f;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_write  = ~w;
        req_funct3 = 3'd7;
        req_addr   = ~a;
        @(negedge clk);
        if (exp_f) begin
            chk({name, ".strobes"}, 32'({bif.read, bif.write}), 32'd0);
        end else begin
            chk({name, ".strobes"}, 32'({bif.read, bif.write}), 32'({~w, w}));
            chk({name, ".address"}, 32'(bif.address), 32'(a[31:2]));
            chk({name, ".byte_en"}, 32'(bif.byte_enable), 32'(exp_be));
            chk({name, ".bus_data"}, bif.data, exp_bd);
        end
        lat = 1;
        while (resp_valid !== 1'b1 && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        chk({name, ".latency"}, 32'(lat), 32'(exp_lat));
        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                chk({name, ".hold_valid"}, 32'(resp_valid), 32'd1);
                chk({name, ".hold_rdata"}, resp_rdata, exp_rd);
                chk({name, ".hold_ready"}, 32'(req_ready), 32'd0);
                chk({name, ".hold_strobes"}, 32'({bif.read, bif.write}), 32'd0);
            end
            @(posedge clk);
            #1 resp_ready = 1'b1;
            @(negedge clk);
            @(negedge clk);
            chk({name, ".ready_after"}, 32'(req_ready), 32'd1);
        end else begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        resp_ready = 1'b1;
        #3;
        chk("rst.req_ready", 32'(req_ready), 32'd1);
        chk("rst.resp_valid", 32'(resp_valid), 32'd0);
        chk("rst.resp_fault", 32'(resp_fault), 32'd0);
        chk("rst.resp_rdata", resp_rdata, 32'd0);
        chk("rst.strobes", 32'({bif.read, bif.write}), 32'd0);
        chk("rst.address", 32'(bif.address), 32'd0);
        chk("rst.data", bif.data, 32'd0);
        chk("rst.byte_en", 32'(bif.byte_enable), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        //      name   w   f3    addr          wdata         exp_rdata     flt   be       bus data      hold
        do_req("lw",   0, 3'd2, 32'h100, 32'h0,        32'hDEADBEEF, 0, 4'hF,   32'h0,        0);
        do_req("lb",   0, 3'd0, 32'h103, 32'h0,        32'hFFFFFFDE, 0, 4'b1000, 32'h0,       0);
        do_req("lbu",  0, 3'd4, 32'h103, 32'h0,        32'h000000DE, 0, 4'b1000, 32'h0,       0);
        do_req("lh",   0, 3'd1, 32'h102, 32'h0,        32'hFFFFDEAD, 0, 4'b1100, 32'h0,       0);
        do_req("lhu",  0, 3'd5, 32'h100, 32'h0,        32'h0000BEEF, 0, 4'b0011, 32'h0,       0);
        do_req("sb",   1, 3'd0, 32'h101, 32'h00000055, 32'h0,        0, 4'b0010, 32'h55555555, 0);
        do_req("lw2",  0, 3'd2, 32'h100, 32'h0,        32'hDEAD55EF, 0, 4'hF,   32'h0,        0);
        do_req("lb0",  0, 3'd0, 32'h100, 32'h0,        32'hFFFFFFEF, 0, 4'b0001, 32'h0,       0);
        do_req("lh0",  0, 3'd1, 32'h100, 32'h0,        32'h000055EF, 0, 4'b0011, 32'h0,       0);
        do_req("sh_mis", 1, 3'd1, 32'h101, 32'h1234,   32'h0,        1, 4'h0,   32'h0,        0);
        do_req("lw_mis", 0, 3'd2, 32'h102, 32'h0,      32'h0,        1, 4'h0,   32'h0,        0);
        do_req("f3_3", 0, 3'd3, 32'h100, 32'h0,        32'h0,        1, 4'h0,   32'h0,        0);
        do_req("sbu",  1, 3'd4, 32'h100, 32'h77,       32'h0,        1, 4'h0,   32'h0,        0);
        do_req("sw",   1, 3'd2, 32'h104, 32'h12345678, 32'h0,        0, 4'hF,   32'h12345678, 0);
        do_req("sh",   1, 3'd1, 32'h106, 32'h0000ABCD, 32'h0,        0, 4'b1100, 32'hABCDABCD, 0);
        do_req("lw3",  0, 3'd2, 32'h104, 32'h0,        32'hABCD5678, 0, 4'hF,   32'h0,        0);
        do_req("lw_stall", 0, 3'd2, 32'h104, 32'h0,    32'hABCD5678, 0, 4'hF,   32'h0,        5);
        chk("mem_after_faults", mem[8'h40], 32'hDEAD55EF);

        // Asynchronous reset while a store is in ACCESS
        @(negedge clk);
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_funct3 = 3'd2;
        req_addr   = 32'h108;
        req_wdata  = 32'hCAFEF00D;
        @(posedge clk);
        #1 req_valid = 1'b0;
        #1 chk("arst.write_before", 32'(bif.write), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst.write_drop", 32'(bif.write), 32'd0);
        chk("arst.req_ready", 32'(req_ready), 32'd1);
        chk("arst.resp_valid", 32'(resp_valid), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("arst.address", 32'(bif.address), 32'd0);
        chk("arst.byte_en", 32'(bif.byte_enable), 32'd0);
        chk("arst.mem", mem[8'h42], 32'h11111111);
        do_req("lw_after_rst", 0, 3'd2, 32'h108, 32'h0, 32'h11111111, 0, 4'hF, 32'h0, 0);

        repeat (2) @(negedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
